// File: rtl/pi_pkg.sv
// pi_pkg: shared types and constants for the parallel-interface transmit path.
package pi_pkg;
  localparam int PI_DW = 8;
  localparam int PI_CW = 16;
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT_ACK,
    RELEASE
  } pi_state_t;
endpackage

// File: rtl/pi_tx_fifo.sv
// pi_tx_fifo: synchronous byte FIFO with registered full/empty flags.
module pi_tx_fifo
  import pi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [PI_DW-1:0] data_i,
  input  logic             pop_i,
  output logic [PI_DW-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [PI_DW-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic full_q, full_d, empty_q, empty_d, push, pop;
  always_comb begin
    push    = push_i & ~full_q;
    pop     = pop_i & ~empty_q;
    wp_d    = wp_q + (AW+1)'(push);
    rp_d    = rp_q + (AW+1)'(pop);
    full_d  = (wp_d[AW] != rp_d[AW]) && (wp_d[AW-1:0] == rp_d[AW-1:0]);
    empty_d = wp_d == rp_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= data_i;
  end
  assign data_o  = mem_q[rp_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/pi_tx_ctrl.sv
// pi_tx_ctrl: FIFO-fed strobe/ack transmitter for the 8-bit parallel interface.
// Define PI_TX_TIMEOUT_EN to enable the WAIT_ACK timeout and the sticky err flag.
module pi_tx_ctrl
  import pi_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STB_CYCLES   = 2,
  parameter int SETUP_CYCLES = 1,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [PI_DW-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [PI_DW-1:0] dout,
  output logic             stb,
  input  logic             ack,
  output logic             busy,
  output logic             err,
  input  logic             err_clr
);
  pi_state_t state_q, state_d;
  logic [PI_CW-1:0] cnt_q, cnt_d;
  logic [PI_DW-1:0] dout_q, dout_d, head;
  logic [1:0] sync_q;
  logic stb_q, busy_q, err_q, err_d, pop, set_err, ack_s;
  assign ack_s = sync_q[1];
  pi_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (wr_en),
    .data_i (wr_data),
    .pop_i  (pop),
    .data_o (head),
    .full_o (full),
    .empty_o(empty)
  );
  // Counters reach "0" on the decremented value, so a load of N spans N clocks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    set_err = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        cnt_d   = PI_CW'(SETUP_CYCLES);
        state_d = SETUP;
      end
      SETUP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          cnt_d   = PI_CW'(STB_CYCLES);
          state_d = STROBE;
        end
      end
      STROBE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          cnt_d   = PI_CW'(ACK_TIMEOUT);
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s) state_d = RELEASE;
`ifdef PI_TX_TIMEOUT_EN
        else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_d == '0) begin
            set_err = 1'b1;
            state_d = RELEASE;
          end
        end
`endif
      end
      RELEASE: if (!ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    dout_d = pop ? head : dout_q;
`ifdef PI_TX_TIMEOUT_EN
    err_d = set_err | (err_q & ~err_clr);
`else
    err_d = 1'b0;
`endif
  end
`ifndef PI_TX_TIMEOUT_EN
  logic unused_err;
  assign unused_err = err_clr | set_err;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      stb_q   <= state_d == STROBE;
      busy_q  <= state_d != IDLE;
      err_q   <= err_d;
      sync_q  <= {sync_q[0], ack};
    end
  end
  assign dout = dout_q;
  assign stb  = stb_q;
  assign busy = busy_q;
  assign err  = err_q;
endmodule

// File: tb/tb_pi_tx_ctrl.sv
// tb_pi_tx_ctrl: directed vector table plus hand sequences for pi_tx_ctrl.
module tb_pi_tx_ctrl;
  logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, ack = 1'b0, err_clr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic full, empty, stb, busy, err;
  logic [7:0] dout;
  int n_vec = 0, n_bad = 0;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ack;
    logic [7:0] e_dout;
    logic       e_stb, e_busy, e_empty, e_full, e_err;
  } vec_t;
  vec_t tv[14];

  pi_tx_ctrl #(.DEPTH(4), .STB_CYCLES(2), .SETUP_CYCLES(1), .ACK_TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .dout(dout), .stb(stb), .ack(ack), .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; wr_en = 1'b0; ack = 1'b0; err_clr = 1'b0; wr_data = 8'h00;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_stb(input logic lvl, input string nm);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (stb === lvl) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk(nm, 32'(stb), 32'(lvl));
  endtask

  task automatic ack_resp(input string nm);
    bit ok = 0;
    ack = 1'b1;
    repeat (4) tick();
    ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk(nm, 32'(busy), 32'd0);
  endtask

  task automatic write(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    bit ok;
    logic [7:0] exp_b;
    //           wr  data   ack  dout   stb busy empty full err
    tv[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[10] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[11] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[12] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[13] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    do_reset();
    chk("reset", {dout, stb, busy, empty, full, err}, {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    ok = 1;
    repeat (20) begin
      tick();
      if ({dout, stb, busy, empty, full, err} !== {8'h00, 5'b00100}) ok = 0;
    end
    chk("idle20", 32'(ok), 32'd1);

    // Single byte A5: ack rises 3 clocks after stb, drops 2 clocks later.
    for (int i = 0; i < 14; i++) begin
      wr_en = tv[i].wr_en; wr_data = tv[i].wr_data; ack = tv[i].ack;
      tick();
      chk($sformatf("vec%0d", i), {dout, stb, busy, empty, full, err},
          {tv[i].e_dout, tv[i].e_stb, tv[i].e_busy, tv[i].e_empty, tv[i].e_full, tv[i].e_err});
    end
    wr_en = 1'b0; ack = 1'b0;

    // FIFO full: stall EE in WAIT_ACK, then push 01..05.
    do_reset();
    write(8'hEE);
    repeat (4) tick();
    for (int i = 1; i <= 5; i++) begin
      write(8'(i));
      chk($sformatf("full_after_%0d", i), 32'(full), 32'(i >= 4));
    end
    ack_resp("ee_done");
    for (int i = 1; i <= 4; i++) begin
      exp_b = 8'(i);
      wait_stb(1'b1, "fifo_stb_hi");
      chk($sformatf("order%0d", i), 32'(dout), 32'(exp_b));
      wait_stb(1'b0, "fifo_stb_lo");
      ack_resp("fifo_done");
    end
    ok = 1;
    repeat (10) begin
      tick();
      if (stb || busy) ok = 0;
    end
    chk("no_05", 32'(ok), 32'd1);
    chk("drained_empty", 32'(empty), 32'd1);

`ifdef PI_TX_TIMEOUT_EN
    do_reset();
    write(8'h3C);
    write(8'h3D);
    wait_stb(1'b1, "to_stb_hi");
    chk("to_dout", 32'(dout), 32'h3C);
    wait_stb(1'b0, "to_stb_lo");
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("err_at_%0d", k), 32'(err), 32'(k == 10));
    end
    wait_stb(1'b1, "next_stb_hi");
    chk("next_dout", 32'(dout), 32'h3D);
    wait_stb(1'b0, "next_stb_lo");
    ack_resp("next_done");
    chk("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'd0);
`else
    do_reset();
    write(8'h3C);
    wait_stb(1'b1, "nt_stb_hi");
    chk("nt_dout", 32'(dout), 32'h3C);
    wait_stb(1'b0, "nt_stb_lo");
    ok = 1;
    err_clr = 1'b1;
    repeat (1000) begin
      tick();
      if (err || !busy || stb) ok = 0;
    end
    err_clr = 1'b0;
    chk("nt_wait1000", 32'(ok), 32'd1);
    ack_resp("nt_done");
    chk("nt_idle", {busy, empty, err}, {1'b0, 1'b1, 1'b0});
`endif

    // Reset during STROBE with a second byte still queued.
    do_reset();
    write(8'hFF);
    write(8'h11);
    wait_stb(1'b1, "rm_stb_hi");
    chk("rm_dout", 32'(dout), 32'hFF);
    #2 rst = 1'b0;
    #1 chk("rm_async", {dout, stb, busy, empty, full, err}, {8'h00, 5'b00100});
    tick();
    rst = 1'b1;
    ok = 1;
    repeat (5) begin
      tick();
      if (!empty || busy || stb) ok = 0;
    end
    chk("rm_empty", 32'(ok), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
